// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit:
// state encoding, opcode/func fields and ALU operation codes.
package mc_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int ALUC_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    SIF  = 3'b000,
    SID  = 3'b001,
    SEXE = 3'b010,
    SMEM = 3'b011,
    SWB  = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  // Bit 3 is a don't-care for the non-shift operations; it is tied to 0.
  localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: op/func to instruction-class flags
// and the ALU operation used in the execute state.
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  output logic              r_alu,
  output logic              shift_op,
  output logic              jr,
  output logic              imm,
  output logic              addi,
  output logic              lw,
  output logic              sw,
  output logic              beq,
  output logic              bne,
  output logic              j,
  output logic              jal,
  output logic              valid,
  output logic [ALUC_W-1:0] aluc
);

  always_comb begin
    r_alu    = 1'b0;
    shift_op = 1'b0;
    jr       = 1'b0;
    imm      = 1'b0;
    addi     = 1'b0;
    lw       = 1'b0;
    sw       = 1'b0;
    beq      = 1'b0;
    bne      = 1'b0;
    j        = 1'b0;
    jal      = 1'b0;
    aluc     = ALUC_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: begin r_alu = 1'b1; aluc = ALUC_ADD; end
          FN_SUB: begin r_alu = 1'b1; aluc = ALUC_SUB; end
          FN_AND: begin r_alu = 1'b1; aluc = ALUC_AND; end
          FN_OR:  begin r_alu = 1'b1; aluc = ALUC_OR;  end
          FN_XOR: begin r_alu = 1'b1; aluc = ALUC_XOR; end
          FN_SLL: begin shift_op = 1'b1; aluc = ALUC_SLL; end
          FN_SRL: begin shift_op = 1'b1; aluc = ALUC_SRL; end
          FN_SRA: begin shift_op = 1'b1; aluc = ALUC_SRA; end
          FN_JR:  jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin imm = 1'b1; addi = 1'b1; aluc = ALUC_ADD; end
      OP_ANDI: begin imm = 1'b1; aluc = ALUC_AND; end
      OP_ORI:  begin imm = 1'b1; aluc = ALUC_OR;  end
      OP_XORI: begin imm = 1'b1; aluc = ALUC_XOR; end
      OP_LUI:  begin imm = 1'b1; aluc = ALUC_LUI; end
      OP_LW:   lw  = 1'b1;
      OP_SW:   sw  = 1'b1;
      OP_BEQ:  begin beq = 1'b1; aluc = ALUC_SUB; end
      OP_BNE:  begin bne = 1'b1; aluc = ALUC_SUB; end
      OP_J:    j   = 1'b1;
      OP_JAL:  jal = 1'b1;
      default: ;
    endcase
  end

  assign valid = r_alu | shift_op | jr | imm | lw | sw | beq | bne | j | jal;

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM (IF/ID/EXE/MEM/WB). Define MEM_WAIT_EN to add
// the mrdy handshake that stalls fetch and memory states for slow memory.
import mc_ctrl_pkg::*;

module mc_control_fsm (
  input  logic               clk,
  input  logic               clr,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               z,
`ifdef MEM_WAIT_EN
  input  logic               mrdy,
`endif
  output logic [STATE_W-1:0] q,
  output logic               wpc,
  output logic               wir,
  output logic               wmem,
  output logic               wreg,
  output logic               iord,
  output logic               regrt,
  output logic               m2reg,
  output logic               shift,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               sext,
  output logic               jal,
  output logic [ALUC_W-1:0]  aluc,
  output logic               retire
);

  state_t state, next_state;
  logic   mem_rdy;
  logic   d_r_alu, d_shift, d_jr, d_imm, d_addi, d_lw, d_sw;
  logic   d_beq, d_bne, d_j, d_jal, d_valid;
  logic [ALUC_W-1:0] d_aluc;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mrdy;
`else
  assign mem_rdy = 1'b1;
`endif

  mc_ctrl_decode u_decode (
    .op       (op),
    .func     (func),
    .r_alu    (d_r_alu),
    .shift_op (d_shift),
    .jr       (d_jr),
    .imm      (d_imm),
    .addi     (d_addi),
    .lw       (d_lw),
    .sw       (d_sw),
    .beq      (d_beq),
    .bne      (d_bne),
    .j        (d_j),
    .jal      (d_jal),
    .valid    (d_valid),
    .aluc     (d_aluc)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= SIF;
    else     state <= next_state;
  end

  assign q = state;

  always_comb begin
    next_state = SIF;
    wpc     = 1'b0;
    wir     = 1'b0;
    wmem    = 1'b0;
    wreg    = 1'b0;
    iord    = 1'b0;
    regrt   = 1'b0;
    m2reg   = 1'b0;
    shift   = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc   = 2'b00;
    sext    = 1'b0;
    jal     = 1'b0;
    aluc    = ALUC_ADD;
    retire  = 1'b0;
    case (state)
      SIF: begin
        wir        = mem_rdy;
        wpc        = mem_rdy;
        alusrcb    = 2'b01;
        next_state = mem_rdy ? SID : SIF;
      end
      // The branch target is computed here speculatively for SEXE to use.
      SID: begin
        alusrcb = 2'b11;
        sext    = 1'b1;
        if (d_j || d_jal) begin
          pcsrc  = 2'b11;
          wpc    = 1'b1;
          wreg   = d_jal;
          jal    = d_jal;
          retire = 1'b1;
        end else if (d_jr) begin
          pcsrc  = 2'b10;
          wpc    = 1'b1;
          retire = 1'b1;
        end else if (!d_valid) begin
          retire = 1'b1;
        end else begin
          next_state = SEXE;
        end
      end
      SEXE: begin
        shift   = d_shift;
        alusrca = ~d_shift;
        aluc    = d_aluc;
        if (d_beq || d_bne) begin
          aluc   = ALUC_SUB;
          pcsrc  = 2'b01;
          wpc    = d_beq ? z : ~z;
          retire = 1'b1;
        end else if (d_lw || d_sw) begin
          alusrcb    = 2'b10;
          sext       = 1'b1;
          aluc       = ALUC_ADD;
          next_state = SMEM;
        end else if (d_imm) begin
          alusrcb    = 2'b10;
          sext       = d_addi;
          next_state = SWB;
        end else if (d_r_alu || d_shift) begin
          next_state = SWB;
        end
      end
      SMEM: begin
        iord = 1'b1;
        if (d_lw) begin
          next_state = mem_rdy ? SWB : SMEM;
        end else if (d_sw) begin
          wmem       = 1'b1;
          retire     = mem_rdy;
          next_state = mem_rdy ? SIF : SMEM;
        end
      end
      SWB: begin
        wreg   = 1'b1;
        retire = 1'b1;
        m2reg  = d_lw;
        regrt  = d_imm | d_lw;
      end
      default: next_state = SIF;
    endcase
    // Reset aborts the instruction: no architectural write may escape.
    if (clr) begin
      wpc    = 1'b0;
      wir    = 1'b0;
      wmem   = 1'b0;
      wreg   = 1'b0;
      retire = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm; MEM_WAIT_EN adds the
// slow-memory scenarios.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic       z = 1'b0;
  logic       mrdy = 1'b1;
  logic [2:0] q;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       sext, jal, retire;
  logic [3:0] aluc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk     (clk),
    .clr     (clr),
    .op      (op),
    .func    (func),
    .z       (z),
`ifdef MEM_WAIT_EN
    .mrdy    (mrdy),
`endif
    .q       (q),
    .wpc     (wpc),
    .wir     (wir),
    .wmem    (wmem),
    .wreg    (wreg),
    .iord    (iord),
    .regrt   (regrt),
    .m2reg   (m2reg),
    .shift   (shift),
    .alusrca (alusrca),
    .alusrcb (alusrcb),
    .pcsrc   (pcsrc),
    .sext    (sext),
    .jal     (jal),
    .aluc    (aluc),
    .retire  (retire)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step();
    checks++; if (q !== 3'b000) begin errors++; $display("[TB] FAIL reset_q got=%b exp=000", q); end
    checks++; if (wpc !== 1'b0 || wir !== 1'b0) begin errors++; $display("[TB] FAIL reset_wpc_wir got=%b%b exp=00", wpc, wir); end
    clr = 1'b0;
    op = 6'b101011;
    step(); step(); step();
    checks++; if (q !== 3'b011) begin errors++; $display("[TB] FAIL sw_smem_q got=%b exp=011", q); end
    checks++; if (wmem !== 1'b1) begin errors++; $display("[TB] FAIL sw_smem_wmem got=%b exp=1", wmem); end
    clr = 1'b1;
    #1;
    checks++; if (wmem !== 1'b0 || retire !== 1'b0) begin errors++; $display("[TB] FAIL clr_in_smem wmem/retire got=%b%b exp=00", wmem, retire); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (q !== 3'b000 || wmem !== 1'b0) begin errors++; $display("[TB] FAIL clr_hold cycle %0d q=%b wmem=%b exp q=000 wmem=0", i, q, wmem); end
    end
    clr = 1'b0;
    #1;
    checks++; if (wpc !== 1'b1 || wir !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_fetch wpc/wir got=%b%b exp=11", wpc, wir); end
  endtask

  task automatic test_add();
    logic [2:0] exp_q [5];
    int retires;
    exp_q[0] = 3'b000; exp_q[1] = 3'b001; exp_q[2] = 3'b010; exp_q[3] = 3'b100; exp_q[4] = 3'b000;
    retires = 0;
    op = 6'b000000; func = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      checks++; if (q !== exp_q[i]) begin errors++; $display("[TB] FAIL add_q step %0d got=%b exp=%b", i, q, exp_q[i]); end
      checks++; if (wreg !== (i == 3)) begin errors++; $display("[TB] FAIL add_wreg step %0d got=%b exp=%b", i, wreg, (i == 3)); end
      if (i == 2) begin
        checks++; if (aluc !== 4'b0000 || alusrcb !== 2'b00 || alusrca !== 1'b1) begin errors++; $display("[TB] FAIL add_exe aluc=%b alusrcb=%b alusrca=%b exp 0000/00/1", aluc, alusrcb, alusrca); end
      end
      if (i == 3) begin
        checks++; if (regrt !== 1'b0) begin errors++; $display("[TB] FAIL add_regrt got=%b exp=0", regrt); end
      end
      if (retire === 1'b1) retires++;
      if (i < 4) step();
    end
    checks++; if (retires != 1) begin errors++; $display("[TB] FAIL add_retire_count got=%0d exp=1", retires); end
  endtask

  task automatic test_shift();
    op = 6'b000000; func = 6'b000011;
    step(); step();
    checks++; if (q !== 3'b010 || shift !== 1'b1 || alusrca !== 1'b0 || aluc !== 4'b1111) begin errors++; $display("[TB] FAIL sra_exe q=%b shift=%b alusrca=%b aluc=%b exp 010/1/0/1111", q, shift, alusrca, aluc); end
    step();
    checks++; if (q !== 3'b100 || wreg !== 1'b1 || regrt !== 1'b0) begin errors++; $display("[TB] FAIL sra_wb q=%b wreg=%b regrt=%b exp 100/1/0", q, wreg, regrt); end
    step();
  endtask

  task automatic test_lw();
    op = 6'b100011;
    step(); step();
    checks++; if (q !== 3'b010 || alusrcb !== 2'b10 || sext !== 1'b1 || aluc !== 4'b0000) begin errors++; $display("[TB] FAIL lw_exe q=%b alusrcb=%b sext=%b aluc=%b exp 010/10/1/0000", q, alusrcb, sext, aluc); end
    step();
    checks++; if (q !== 3'b011 || iord !== 1'b1 || wreg !== 1'b0 || wmem !== 1'b0) begin errors++; $display("[TB] FAIL lw_mem q=%b iord=%b wreg=%b wmem=%b exp 011/1/0/0", q, iord, wreg, wmem); end
    step();
    checks++; if (q !== 3'b100 || m2reg !== 1'b1 || regrt !== 1'b1 || wreg !== 1'b1 || retire !== 1'b1) begin errors++; $display("[TB] FAIL lw_wb q=%b m2reg=%b regrt=%b wreg=%b retire=%b exp 100/1/1/1/1", q, m2reg, regrt, wreg, retire); end
    step();
    checks++; if (q !== 3'b000) begin errors++; $display("[TB] FAIL lw_end q got=%b exp=000", q); end
  endtask

  task automatic test_branch();
    logic [5:0] ops  [4];
    logic       zs   [4];
    logic       wexp [4];
    ops[0] = 6'b000100; zs[0] = 1'b1; wexp[0] = 1'b1;
    ops[1] = 6'b000100; zs[1] = 1'b0; wexp[1] = 1'b0;
    ops[2] = 6'b000101; zs[2] = 1'b0; wexp[2] = 1'b1;
    ops[3] = 6'b000101; zs[3] = 1'b1; wexp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op = ops[i]; z = zs[i];
      step(); step();
      checks++; if (q !== 3'b010 || wpc !== wexp[i]) begin errors++; $display("[TB] FAIL branch %0d q=%b wpc=%b exp 010/%b", i, q, wpc, wexp[i]); end
      checks++; if (pcsrc !== 2'b01 || aluc !== 4'b0100 || retire !== 1'b1 || wreg !== 1'b0) begin errors++; $display("[TB] FAIL branch_ctl %0d pcsrc=%b aluc=%b retire=%b wreg=%b exp 01/0100/1/0", i, pcsrc, aluc, retire, wreg); end
      step();
      checks++; if (q !== 3'b000) begin errors++; $display("[TB] FAIL branch_end %0d q got=%b exp=000", i, q); end
    end
    z = 1'b0;
  endtask

  task automatic test_jumps();
    op = 6'b000011;
    step();
    checks++; if (q !== 3'b001 || pcsrc !== 2'b11 || wpc !== 1'b1 || wreg !== 1'b1 || jal !== 1'b1 || retire !== 1'b1) begin errors++; $display("[TB] FAIL jal_id q=%b pcsrc=%b wpc=%b wreg=%b jal=%b retire=%b exp 001/11/1/1/1/1", q, pcsrc, wpc, wreg, jal, retire); end
    step();
    checks++; if (q !== 3'b000) begin errors++; $display("[TB] FAIL jal_end q got=%b exp=000", q); end
    op = 6'b000000; func = 6'b001000;
    step();
    checks++; if (pcsrc !== 2'b10 || wpc !== 1'b1 || wreg !== 1'b0 || jal !== 1'b0) begin errors++; $display("[TB] FAIL jr_id pcsrc=%b wpc=%b wreg=%b jal=%b exp 10/1/0/0", pcsrc, wpc, wreg, jal); end
    step();
  endtask

  task automatic test_undefined();
    op = 6'b111111;
    step();
    checks++; if (q !== 3'b001 || wpc !== 1'b0 || wreg !== 1'b0 || wmem !== 1'b0 || retire !== 1'b1) begin errors++; $display("[TB] FAIL undef_id q=%b wpc=%b wreg=%b wmem=%b retire=%b exp 001/0/0/0/1", q, wpc, wreg, wmem, retire); end
    step();
    checks++; if (q !== 3'b000) begin errors++; $display("[TB] FAIL undef_end q got=%b exp=000", q); end
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    int wmem_cycles;
    wmem_cycles = 0;
    op = 6'b101011; mrdy = 1'b0;
    #1;
    checks++; if (q !== 3'b000 || wir !== 1'b0 || wpc !== 1'b0) begin errors++; $display("[TB] FAIL fetch_wait q=%b wir=%b wpc=%b exp 000/0/0", q, wir, wpc); end
    step();
    checks++; if (q !== 3'b000) begin errors++; $display("[TB] FAIL fetch_hold q got=%b exp=000", q); end
    mrdy = 1'b1;
    step(); step();
    mrdy = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (q !== 3'b011 || retire !== 1'b0) begin errors++; $display("[TB] FAIL sw_wait %0d q=%b retire=%b exp 011/0", i, q, retire); end
      if (wmem === 1'b1) wmem_cycles++;
      step();
    end
    mrdy = 1'b1;
    #1;
    checks++; if (q !== 3'b011 || retire !== 1'b1) begin errors++; $display("[TB] FAIL sw_ready q=%b retire=%b exp 011/1", q, retire); end
    if (wmem === 1'b1) wmem_cycles++;
    checks++; if (wmem_cycles != 4) begin errors++; $display("[TB] FAIL sw_wmem_cycles got=%0d exp=4", wmem_cycles); end
    step();
    checks++; if (q !== 3'b000) begin errors++; $display("[TB] FAIL sw_wait_end q got=%b exp=000", q); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_lw();
    test_branch();
    test_jumps();
    test_undefined();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Control unit for the multicycle MIPS computer.
- Sequences the shared ALU, the single memory port, PC, IR and register file through the fetch / decode / execute / memory / write-back states.
- Decodes the op and func fields of IR, plus the ALU zero flag, into per-state datapath enables and mux selects.
- Exposes the 3-bit state as q for the top-level debug bus.

Parameters:
- STATE_W, 3, state register width. Fixed; exported on q.
- ALUC_W, 4, ALU control width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- z  in  1  ALU zero flag, valid in the cycle it is used.
- q  out  3  current state.
- wpc  out  1  PC write enable.
- wir  out  1  IR write enable.
- wmem  out  1  memory write enable.
- wreg  out  1  register-file write enable.
- iord  out  1  memory address select: 0=PC, 1=ALU register.
- regrt  out  1  destination register select: 1=rt, 0=rd.
- m2reg  out  1  write-back data select: 1=memory data, 0=ALU.
- shift  out  1  ALU A input select: 1=shamt.
- alusrca  out  1  ALU A input select: 0=PC, 1=register A.
- alusrcb  out  2  ALU B input select: 00=B, 01=4, 10=imm, 11=imm<<2.
- pcsrc  out  2  next-PC select: 00=ALU, 01=branch register, 10=rs, 11=jump target.
- sext  out  1  immediate extension: 1=sign, 0=zero.
- jal  out  1  force destination r31 and data PC.
- aluc  out  4  ALU operation.
- retire  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- States: SIF=000, SID=001, SEXE=010, SMEM=011, SWB=100.
- q is registered. All other outputs are combinational from q, op, func and z.
- Reset:
  - clr=1 at a rising edge loads q=SIF.
  - While clr=1, wpc, wir, wmem, wreg and retire are forced to 0.
  - A reset in any state, including SMEM with wmem pending, aborts the instruction with no write.
- Default output value is 0 unless listed below.
- Supported instructions:
  - R-type: add, sub, and, or, xor, sll, srl, sra, jr.
  - I-type: addi, andi, ori, xori, lw, sw, beq, bne, lui.
  - J-type: j, jal.
- SIF: iord=0, wir=1, alusrca=0, alusrcb=01, aluc=ADD, pcsrc=00, wpc=1. Next state SID.
- SID: alusrca=0, alusrcb=11, sext=1, aluc=ADD (branch target into ALU register).
  - j: pcsrc=11, wpc=1, retire=1. Next state SIF.
  - jal: as j, plus wreg=1, jal=1.
  - jr: pcsrc=10, wpc=1, retire=1. Next state SIF.
  - Undefined op/func: no writes, retire=1, next state SIF (treated as NOP).
  - Otherwise: next state SEXE.
- SEXE: alusrca=~shift, with aluc from the decode table.
  - beq/bne: alusrcb=00, aluc=SUB, pcsrc=01, wpc=z (beq) or ~z (bne), retire=1. Next state SIF.
  - lw/sw: alusrcb=10, sext=1, aluc=ADD. Next state SMEM.
  - Immediates: alusrcb=10; sext=1 for addi only. Next state SWB.
  - Shifts: shift=1.
  - lui: aluc=LUI.
- SMEM: iord=1.
  - lw: next state SWB.
  - sw: wmem=1, retire=1. Next state SIF.
- SWB: wreg=1, retire=1.
  - m2reg=1 for lw.
  - regrt=1 for I-type.
  - Next state SIF.
- Cycle counts: branch/sw/R/I = 3 or 4, lw = 5, j/jal/jr = 2.
- Encodings outside the five states go to SIF on the next edge with no writes.

Optional Feature:
- MEM_WAIT_EN defined:
  - Adds input mrdy (1 bit) for a slow memory.
  - In SIF, wir and wpc are asserted only in the cycle where mrdy=1; q holds in SIF until then.
  - In SMEM, q holds until mrdy=1. For sw, wmem is held high through the whole wait and retire pulses on the mrdy=1 cycle.
  - mrdy is ignored in all other states.
- Undefined: no mrdy port; memory is assumed single-cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum;
  - opcode and func constants;
  - ALUC constants: ADD=x000, SUB=x100, AND=x001, OR=x101, XOR=x010, LUI=x110, SLL=0011, SRL=0111, SRA=1111.
- Sub-module mc_ctrl_decode: combinational op/func to instruction-class flags and aluc. The FSM instantiates it once.

Test Plan:
- Reset: clr=1 for 2 cycles while in SMEM of sw → q=000, wmem=0 throughout; after release the next cycle shows wpc=wir=1.
- add (op=0, func=100000) → q sequence 000,001,010,100,000; wreg=1 and regrt=0 only in SWB; aluc=0000; retire pulses once.
- lw (op=100011) → 5 states; iord=1 in SMEM; m2reg=1, regrt=1, wreg=1 in SWB.
- beq (op=000100):
  - z=1 → wpc=1, pcsrc=01 in SEXE.
  - z=0 → wpc=0.
  - bne with z=0 → wpc=1.
- jal (op=000011) → 2 cycles; SID shows pcsrc=11, wpc=1, wreg=1, jal=1.
- MEM_WAIT_EN: sw with mrdy low for 3 cycles in SMEM → q=011 held, wmem=1 for 4 cycles, retire on the mrdy cycle; undefined op=111111 → SIF after SID with no writes.
